// File: rtl/ahb_single_master.sv
// ahb_single_master: AHB-Lite initiator that turns a valid/ready request port
// into SINGLE transfers. The next request's address phase overlaps the current
// data phase. HREADY wait states are absorbed, and the two-cycle ERROR response
// is handled by parking the queued address phase and replaying it afterwards.

// Bus encodings shared with the rest of the fabric (AHB_def.svh). The guards
// let this file compile on its own when that header is not included first.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif
`ifndef AHB_TRANS_IDLE
`define AHB_TRANS_IDLE 2'b00
`endif
`ifndef AHB_TRANS_NONSEQ
`define AHB_TRANS_NONSEQ 2'b10
`endif
`ifndef AHB_RESP_OKAY
`define AHB_RESP_OKAY 2'b00
`endif
`ifndef AHB_RESP_ERROR
`define AHB_RESP_ERROR 2'b01
`endif

module ahb_single_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_write,
  input  logic [2:0]                 req_size,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_error,
  output logic [ADDR_W-1:0]          HADDR,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [3:0]                 HPROT,
  output logic [`AHB_TRANS_BITS-1:0] HTRANS,
  output logic [DATA_W-1:0]          HWDATA,
  input  logic [DATA_W-1:0]          HRDATA,
  input  logic                       HREADY,
  input  logic [`AHB_RESP_BITS-1:0]  HRESP
);

  // Cycle-level qualifiers derived from the slots and the bus response.
  logic err1_s;      // first ERROR cycle of the current data phase
  logic advance_s;   // address phase is accepted by the bus this cycle
  logic complete_s;  // data phase finishes this cycle
  logic ready_s;
  logic accept_s;

  // Address-phase slot.
  logic              a_valid_q, a_valid_d;
  logic              a_hold_q,  a_hold_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              write_q,   write_d;
  logic [2:0]        size_q,    size_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;

  // Data-phase slot.
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

  // Registered bus and response outputs.
  logic [`AHB_TRANS_BITS-1:0] htrans_q, htrans_d;
  logic [DATA_W-1:0]          hwdata_q, hwdata_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0]          rsp_rdata_q, rsp_rdata_d;

  // Decode handshake and bus-progress conditions from current state.
  always_comb begin
    err1_s     = d_valid_q & ~HREADY & (HRESP == `AHB_RESP_ERROR);
    advance_s  = a_valid_q & ~a_hold_q & HREADY;
    complete_s = d_valid_q & HREADY;
    ready_s    = ~HRESET & (~a_valid_q | advance_s) & ~err1_s;
    accept_s   = req_valid & ready_s;
  end

  // Next state of both slots and of every registered output.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_hold_d    = a_hold_q;
    addr_d      = addr_q;
    write_d     = write_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;

    // Address slot: load on accept (only possible when it is free or moving on).
    if (accept_s) begin
      a_valid_d = 1'b1;
      addr_d    = req_addr;
      write_d   = req_write;
      size_d    = req_size;
      wdata_d   = req_wdata;
    end else if (advance_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end

    // Park the queued address phase across an ERROR; release once it completes.
    if (err1_s & a_valid_q) begin
      a_hold_d = 1'b1;
    end else if (complete_s) begin
      a_hold_d = 1'b0;
    end else begin
      a_hold_d = a_hold_q;
    end

    // Data slot: refilled by an advancing address phase, emptied on completion.
    if (advance_s) begin
      d_valid_d = 1'b1;
      d_write_d = write_q;
      d_wdata_d = wdata_q;
    end else if (complete_s) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end

    if (a_valid_d & ~a_hold_d) begin
      htrans_d = `AHB_TRANS_NONSEQ;
    end else begin
      htrans_d = `AHB_TRANS_IDLE;
    end

    if (d_valid_d & d_write_d) begin
      hwdata_d = d_wdata_d;
    end else begin
      hwdata_d = {DATA_W{1'b0}};
    end

    rsp_valid_d = complete_s;
    rsp_error_d = complete_s & (HRESP == `AHB_RESP_ERROR);
    if (complete_s & ~d_write_q) begin
      rsp_rdata_d = HRDATA;
    end else begin
      rsp_rdata_d = {DATA_W{1'b0}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_hold_q    <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      wdata_q     <= {DATA_W{1'b0}};
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= {DATA_W{1'b0}};
      htrans_q    <= `AHB_TRANS_IDLE;
      hwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      a_valid_q   <= a_valid_d;
      a_hold_q    <= a_hold_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Drive ports from registers; HBURST/HPROT are fixed for single transfers.
  always_comb begin
    req_ready = ready_s;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_error = rsp_error_q;
    HADDR     = addr_q;
    HWRITE    = write_q;
    HSIZE     = size_q;
    HBURST    = 3'b000;
    HPROT     = HPROT_VAL;
    HTRANS    = htrans_q;
    HWDATA    = hwdata_q;
  end

endmodule

// File: tb/tb_ahb_single_master.sv
// Self-checking bench for ahb_single_master. The bench plays the AHB slave
// (address-decoded wait states and a two-cycle ERROR for unmapped space) and
// keeps a scoreboard of expected responses pushed at request acceptance.
module tb_ahb_single_master;

  localparam logic [1:0]  T_IDLE   = 2'b00;
  localparam logic [1:0]  T_NONSEQ = 2'b10;
  localparam logic [1:0]  R_OKAY   = 2'b00;
  localparam logic [1:0]  R_ERROR  = 2'b01;
  localparam logic [31:0] WS_ADDR  = 32'h0000_2000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS, HRESP;

  ahb_single_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; } bus_t;
  exp_t exp_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_count = 0;

  // Slave model state
  logic        dp_active = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  logic        dp_write = 1'b0;
  logic        err_stage = 1'b0;
  int          ws_left = 0;

  // Per-cycle snapshots taken at the falling edge
  logic        s_hreset, s_req_ready, s_accept, s_rsp_valid, s_rsp_error, s_hwrite, s_hready;
  logic [31:0] s_rsp_rdata, s_haddr, s_hwdata;
  logic [2:0]  s_hsize;
  logic [1:0]  s_htrans;

  logic        chk_bus = 1'b0;
  logic        wd_pend = 1'b0;
  logic [31:0] wd_exp = 32'h0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic unmapped(input logic [31:0] a);
    return (a[31:28] == 4'hF);
  endfunction

  task automatic set_req(input logic v, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic [31:0] d);
    req_valid = v; req_addr = a; req_write = w; req_size = sz; req_wdata = d;
  endtask

  // One bus cycle: slave drive, falling-edge sample + scoreboard, slave update.
  task automatic step();
    exp_t e;
    bus_t b;
    if (!dp_active) begin
      HREADY = 1'b1; HRESP = R_OKAY; HRDATA = 32'h0;
    end else if (unmapped(dp_addr)) begin
      HREADY = err_stage; HRESP = R_ERROR; HRDATA = 32'h0;
    end else if (ws_left != 0) begin
      HREADY = 1'b0; HRESP = R_OKAY; HRDATA = 32'hBAD0_0001;
    end else if (dp_write) begin
      HREADY = 1'b1; HRESP = R_OKAY; HRDATA = 32'hBAD0_0002;
    end else begin
      HREADY = 1'b1; HRESP = R_OKAY; HRDATA = rd_word(dp_addr);
    end
    @(negedge HCLK);
    s_hreset = HRESET; s_req_ready = req_ready; s_accept = req_valid & req_ready;
    s_rsp_valid = rsp_valid; s_rsp_rdata = rsp_rdata; s_rsp_error = rsp_error;
    s_htrans = HTRANS; s_haddr = HADDR; s_hwrite = HWRITE; s_hsize = HSIZE;
    s_hwdata = HWDATA; s_hready = HREADY;
    if (s_rsp_valid === 1'b1) begin
      rsp_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_rsp: got rsp rdata=%h err=%b, required no response", s_rsp_rdata, s_rsp_error);
      end else begin
        e = exp_q.pop_front();
        if (s_rsp_rdata !== e.rdata || s_rsp_error !== e.err) begin
          n_fail++;
          $display("FAIL sb_rsp: got rdata=%h err=%b, required rdata=%h err=%b", s_rsp_rdata, s_rsp_error, e.rdata, e.err);
        end
      end
    end
    if (wd_pend) begin
      wd_pend = 1'b0;
      n_checks++;
      if (s_hwdata !== wd_exp) begin
        n_fail++;
        $display("FAIL sb_hwdata: got %h, required %h", s_hwdata, wd_exp);
      end
    end
    if (chk_bus && s_htrans == T_NONSEQ && s_hready) begin
      n_checks++;
      if (bus_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_addr: NONSEQ at %h with no request pending", s_haddr);
      end else begin
        b = bus_q.pop_front();
        if (s_haddr !== b.addr || s_hwrite !== b.write) begin
          n_fail++;
          $display("FAIL sb_addr: got haddr=%h hwrite=%b, required haddr=%h hwrite=%b", s_haddr, s_hwrite, b.addr, b.write);
        end
        wd_pend = 1'b1;
        wd_exp = b.write ? b.wdata : 32'h0;
      end
    end
    if (s_accept) begin
      e.rdata = (req_write || unmapped(req_addr)) ? 32'h0 : rd_word(req_addr);
      e.err = unmapped(req_addr);
      exp_q.push_back(e);
      if (chk_bus) begin
        b.addr = req_addr; b.write = req_write; b.wdata = req_wdata;
        bus_q.push_back(b);
      end
    end
    @(posedge HCLK);
    #1;
    if (s_hreset) begin
      dp_active = 1'b0; err_stage = 1'b0; ws_left = 0;
    end else if (s_hready) begin
      dp_active = (s_htrans == T_NONSEQ); dp_addr = s_haddr; dp_write = s_hwrite;
      err_stage = 1'b0; ws_left = (s_haddr == WS_ADDR) ? 2 : 0;
    end else if (dp_active && unmapped(dp_addr)) begin
      err_stage = 1'b1;
    end else if (ws_left != 0) begin
      ws_left--;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    step(); step();
  endtask

  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input string name);
    int n = 0;
    logic got = 1'b0;
    set_req(1'b1, a, w, 3'd2, d);
    while (!got && n < 20) begin step(); n++; got = s_accept; end
    set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL %s_accept: not accepted in 20 cycles, required acceptance", name); end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    set_req(1'b1, 32'h1234, 1'b1, 3'd2, 32'hFFFF_FFFF);
    step(); step();
    n_checks++;
    if (s_req_ready !== 1'b0 || s_htrans !== T_IDLE || s_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: ready=%b htrans=%h rsp_valid=%b, required 0/0/0", s_req_ready, s_htrans, s_rsp_valid);
    end
    n_checks++;
    if (s_haddr !== 32'h0 || s_hwrite !== 1'b0 || s_hsize !== 3'd0 || s_hwdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: haddr=%h hwrite=%b hsize=%h hwdata=%h, required all 0", s_haddr, s_hwrite, s_hsize, s_hwdata);
    end
    n_checks++;
    if (s_rsp_rdata !== 32'h0 || s_rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: rdata=%h err=%b, required 0/0", s_rsp_rdata, s_rsp_error);
    end
    n_checks++;
    if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin
      n_fail++; $display("FAIL const_ctrl: hburst=%h hprot=%h, required 0/3", HBURST, HPROT);
    end
    HRESET = 1'b0;
    set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    step();
    n_checks++;
    if (s_htrans !== T_IDLE || s_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: htrans=%h ready=%b, required 0/1", s_htrans, s_req_ready);
    end
  endtask

  task automatic test_single_read();
    set_req(1'b1, 32'h1000, 1'b0, 3'd2, 32'h0);
    step();
    n_checks++;
    if (s_accept !== 1'b1) begin n_fail++; $display("FAIL t1_accept: got %b, required 1", s_accept); end
    set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    step();
    n_checks++;
    if (s_htrans !== T_NONSEQ || s_haddr !== 32'h1000 || s_hwrite !== 1'b0 || s_hsize !== 3'd2) begin
      n_fail++; $display("FAIL t1_addr_phase: htrans=%h haddr=%h hwrite=%b hsize=%h, required 2/1000/0/2", s_htrans, s_haddr, s_hwrite, s_hsize);
    end
    step();
    n_checks++;
    if (s_htrans !== T_IDLE || s_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL t1_data_phase: htrans=%h rsp_valid=%b, required 0/0", s_htrans, s_rsp_valid);
    end
    step();
    n_checks++;
    if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'hDEAD_BEEF || s_rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL t1_rsp: valid=%b rdata=%h err=%b, required 1/deadbeef/0", s_rsp_valid, s_rsp_rdata, s_rsp_error);
    end
    drain("t1");
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [0:2];
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) set_req(1'b1, 32'(c * 4), 1'b1, 3'd2, wd[c]);
      else set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
      step();
      if (c < 3) begin
        n_checks++;
        if (s_accept !== 1'b1) begin n_fail++; $display("FAIL t2_accept%0d: got %b, required 1", c, s_accept); end
      end
      if (c >= 1) begin
        n_checks++;
        if (c <= 3 && (s_htrans !== T_NONSEQ || s_haddr !== 32'((c - 1) * 4))) begin
          n_fail++; $display("FAIL t2_addr%0d: htrans=%h haddr=%h, required 2/%h", c, s_htrans, s_haddr, (c - 1) * 4);
        end else if (c > 3 && s_htrans !== T_IDLE) begin
          n_fail++; $display("FAIL t2_idle%0d: htrans=%h, required 0", c, s_htrans);
        end
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (s_hwdata !== wd[c - 2]) begin n_fail++; $display("FAIL t2_hwdata%0d: got %h, required %h", c, s_hwdata, wd[c - 2]); end
      end
      n_checks++;
      if (s_rsp_valid !== (c >= 3 && c <= 5)) begin
        n_fail++; $display("FAIL t2_rsp_valid%0d: got %b, required %b", c, s_rsp_valid, (c >= 3 && c <= 5));
      end
    end
    drain("t2");
  endtask

  task automatic test_wait_state();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: set_req(1'b1, WS_ADDR, 1'b0, 3'd2, 32'h0);
        1: set_req(1'b1, 32'h3000, 1'b0, 3'd2, 32'h0);
        2: set_req(1'b1, 32'h3004, 1'b1, 3'd2, 32'h77);
        default: ;
      endcase
      step();
      if (c == 4) set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
      if (c <= 1) begin
        n_checks++;
        if (s_accept !== 1'b1) begin n_fail++; $display("FAIL t3_accept%0d: got %b, required 1", c, s_accept); end
      end else if (c <= 3) begin
        n_checks++;
        if (s_req_ready !== 1'b0 || s_htrans !== T_NONSEQ || s_haddr !== 32'h3000 || s_hwdata !== 32'h0 || s_rsp_valid !== 1'b0) begin
          n_fail++; $display("FAIL t3_hold%0d: ready=%b htrans=%h haddr=%h hwdata=%h rsp=%b, required 0/2/3000/0/0",
                             c, s_req_ready, s_htrans, s_haddr, s_hwdata, s_rsp_valid);
        end
      end else if (c == 4) begin
        n_checks++;
        if (s_accept !== 1'b1 || s_rsp_valid !== 1'b0) begin
          n_fail++; $display("FAIL t3_release: accept=%b rsp=%b, required 1/0", s_accept, s_rsp_valid);
        end
      end else begin
        n_checks++;
        if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== rd_word(WS_ADDR)) begin
          n_fail++; $display("FAIL t3_rsp: valid=%b rdata=%h, required 1/%h", s_rsp_valid, s_rsp_rdata, rd_word(WS_ADDR));
        end
      end
    end
    drain("t3");
  endtask

  task automatic test_error();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: set_req(1'b1, 32'hF000_0000, 1'b1, 3'd2, 32'h99);
        1: set_req(1'b1, 32'h4000, 1'b0, 3'd2, 32'h0);
        default: set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
      endcase
      step();
      n_checks++;
      case (c)
        0, 1: if (s_accept !== 1'b1) begin n_fail++; $display("FAIL t4_accept%0d: got %b, required 1", c, s_accept); end
        2: if (s_req_ready !== 1'b0 || s_htrans !== T_NONSEQ || s_haddr !== 32'h4000 || s_hwdata !== 32'h99 || s_rsp_valid !== 1'b0) begin
             n_fail++; $display("FAIL t4_err1: ready=%b htrans=%h haddr=%h hwdata=%h rsp=%b, required 0/2/4000/99/0",
                                s_req_ready, s_htrans, s_haddr, s_hwdata, s_rsp_valid);
           end
        3: if (s_htrans !== T_IDLE || s_req_ready !== 1'b0 || s_rsp_valid !== 1'b0) begin
             n_fail++; $display("FAIL t4_err2: htrans=%h ready=%b rsp=%b, required 0/0/0", s_htrans, s_req_ready, s_rsp_valid);
           end
        4: if (s_rsp_valid !== 1'b1 || s_rsp_error !== 1'b1 || s_htrans !== T_NONSEQ || s_haddr !== 32'h4000) begin
             n_fail++; $display("FAIL t4_replay: rsp=%b err=%b htrans=%h haddr=%h, required 1/1/2/4000",
                                s_rsp_valid, s_rsp_error, s_htrans, s_haddr);
           end
        5: if (s_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t4_gap: rsp=%b, required 0", s_rsp_valid); end
        default: if (s_rsp_valid !== 1'b1 || s_rsp_error !== 1'b0 || s_rsp_rdata !== rd_word(32'h4000)) begin
             n_fail++; $display("FAIL t4_read_rsp: rsp=%b err=%b rdata=%h, required 1/0/%h",
                                s_rsp_valid, s_rsp_error, s_rsp_rdata, rd_word(32'h4000));
           end
      endcase
    end
    drain("t4");
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, WS_ADDR, 1'b0, 3'd2, 32'h0); step();
    set_req(1'b1, 32'h3000, 1'b0, 3'd2, 32'h0); step();
    set_req(1'b1, 32'h6000, 1'b1, 3'd2, 32'hAB); step();
    n_checks++;
    if (s_htrans !== T_NONSEQ || s_haddr !== 32'h3000 || s_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL t5_wait: htrans=%h haddr=%h ready=%b, required 2/3000/0", s_htrans, s_haddr, s_req_ready);
    end
    HRESET = 1'b1;
    exp_q.delete();
    step();
    n_checks++;
    if (s_req_ready !== 1'b0) begin n_fail++; $display("FAIL t5_ready_in_reset: got %b, required 0", s_req_ready); end
    HRESET = 1'b0;
    set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    step();
    n_checks++;
    if (s_htrans !== T_IDLE || s_rsp_valid !== 1'b0 || s_haddr !== 32'h0 || s_hwdata !== 32'h0) begin
      n_fail++; $display("FAIL t5_after_reset: htrans=%h rsp=%b haddr=%h hwdata=%h, required 0/0/0/0", s_htrans, s_rsp_valid, s_haddr, s_hwdata);
    end
    for (int i = 0; i < 4; i++) step();
    send(32'h5004, 1'b0, 32'h0, "t5_rd");
    send(32'h5008, 1'b1, 32'hCAFE, "t5_wr");
    drain("t5");
  endtask

  task automatic test_random();
    int n_sent = 0;
    int cyc = 0;
    int rc0 = rsp_count;
    logic [31:0] a, d;
    logic w;
    logic [2:0] sz;
    chk_bus = 1'b1;
    bus_q.delete();
    a = 32'h0001_0000 | (32'($urandom_range(0, 16383)) << 2);
    w = 1'($urandom_range(0, 1)); d = $urandom; sz = 3'($urandom_range(0, 2));
    while (n_sent < 100 && cyc < 400) begin
      set_req(1'b1, a, w, sz, d);
      step();
      cyc++;
      if (s_accept) begin
        n_sent++;
        a = 32'h0001_0000 | (32'($urandom_range(0, 16383)) << 2);
        w = 1'($urandom_range(0, 1)); d = $urandom; sz = 3'($urandom_range(0, 2));
      end
    end
    set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    drain("t6");
    n_checks++;
    if (n_sent != 100 || cyc != 100) begin
      n_fail++; $display("FAIL t6_throughput: sent=%0d cycles=%0d, required 100/100", n_sent, cyc);
    end
    n_checks++;
    if (rsp_count - rc0 != 100 || bus_q.size() != 0) begin
      n_fail++; $display("FAIL t6_count: responses=%0d unissued=%0d, required 100/0", rsp_count - rc0, bus_q.size());
    end
    chk_bus = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    HREADY = 1'b1; HRESP = R_OKAY; HRDATA = 32'h0;
    set_req(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_state();
    test_error();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
